// File: rtl/four_way_phase_scheduler_pkg.sv
// Shared definitions for the four-way phase scheduler: light encodings, phase codes, approach indices.
// Phase codes widen to 3 bits when PED_PHASE_EN is defined.
package four_way_phase_scheduler_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [11:0] ALL_RED     = {4{LIGHT_RED}};

  typedef enum logic [1:0] {APP_N = 2'd0, APP_E = 2'd1, APP_S = 2'd2, APP_W = 2'd3} approach_e;

`ifdef PED_PHASE_EN
  localparam int PH_W = 3;
  typedef enum logic [PH_W-1:0] {
    PH_IDLE = 3'd0, PH_GREEN = 3'd1, PH_YELLOW = 3'd2, PH_ALLRED = 3'd3, PH_WALK = 3'd4
  } phase_e;
`else
  localparam int PH_W = 2;
  typedef enum logic [PH_W-1:0] {
    PH_IDLE = 2'd0, PH_GREEN = 2'd1, PH_YELLOW = 2'd2, PH_ALLRED = 2'd3
  } phase_e;
`endif

  // Only the granted approach can ever be non-red.
  function automatic logic [11:0] light_word(input phase_e ph, input logic [1:0] g);
    logic [11:0] w;
    w = ALL_RED;
    if (ph == PH_GREEN)
      w[3*g +: 3] = LIGHT_GREEN;
    else if (ph == PH_YELLOW)
      w[3*g +: 3] = LIGHT_YELLOW;
    return w;
  endfunction

endpackage

// File: rtl/four_way_phase_scheduler_rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin; search starts after 'last', 'last' itself is checked last.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/four_way_phase_scheduler.sv
// Four-approach traffic phase scheduler: round-robin green with min/max green, yellow and all-red clearance.
// Optional pedestrian walk phase enabled by defining PED_PHASE_EN.
module four_way_phase_scheduler
  import four_way_phase_scheduler_pkg::*;
#(
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 25,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2,
`ifdef PED_PHASE_EN
  parameter int PED_T     = 8,
`endif
  parameter int CNT_W     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      car_req,
`ifdef PED_PHASE_EN
  input  logic            ped_req,
  output logic            walk,
`endif
  output logic [11:0]     light,
  output logic [1:0]      grant,
  output logic [PH_W-1:0] phase,
  output logic            phase_done
);

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1  = CNT_W'(ALLRED_T - 1);

  phase_e           ph_q, nxt_ph;
  logic [CNT_W-1:0] cnt_q, nxt_cnt;
  logic [1:0]       nxt_grant, arb_winner;
  logic             arb_any;
  logic [11:0]      nxt_light;
  logic             nxt_done;
  logic [3:0]       others;
  logic             green_exit;

  rr_arbiter4 u_arb (
    .req    (car_req),
    .last   (grant),
    .winner (arb_winner),
    .any    (arb_any)
  );

  assign others     = car_req & ~(4'b0001 << grant);
  assign green_exit = (cnt_q >= MIN_M1) && (others != 4'b0000) &&
                      (!car_req[grant] || (cnt_q == MAX_M1));
  assign phase      = ph_q;

`ifdef PED_PHASE_EN
  localparam logic [CNT_W-1:0] PED_M1 = CNT_W'(PED_T - 1);
  logic ped_pending, ped_go, nxt_walk;
  assign ped_go   = ped_pending | ped_req;
  assign nxt_walk = (nxt_ph == PH_WALK);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_q       <= PH_IDLE;
      cnt_q      <= '0;
      grant      <= APP_W;
      light      <= ALL_RED;
      phase_done <= 1'b0;
`ifdef PED_PHASE_EN
      walk        <= 1'b0;
      ped_pending <= 1'b0;
`endif
    end else begin
      ph_q       <= nxt_ph;
      cnt_q      <= nxt_cnt;
      grant      <= nxt_grant;
      light      <= nxt_light;
      phase_done <= nxt_done;
`ifdef PED_PHASE_EN
      walk        <= nxt_walk;
      ped_pending <= ped_go & ~(nxt_walk && (ph_q != PH_WALK));
`endif
    end
  end

  always_comb begin
    nxt_ph    = ph_q;
    nxt_cnt   = cnt_q;
    nxt_grant = grant;
    case (ph_q)
      PH_IDLE: begin
`ifdef PED_PHASE_EN
        if (ped_go) begin
          nxt_ph  = PH_WALK;
          nxt_cnt = '0;
        end else
`endif
        if (arb_any) begin
          nxt_ph    = PH_GREEN;
          nxt_grant = arb_winner;
          nxt_cnt   = '0;
        end
      end
      PH_GREEN: begin
        if (green_exit) begin
          nxt_ph  = PH_YELLOW;
          nxt_cnt = '0;
        end else if (cnt_q != MAX_M1) begin
          nxt_cnt = cnt_q + 1'b1;
        end
      end
      PH_YELLOW: begin
        if (cnt_q == YEL_M1) begin
          nxt_ph  = PH_ALLRED;
          nxt_cnt = '0;
        end else begin
          nxt_cnt = cnt_q + 1'b1;
        end
      end
      PH_ALLRED: begin
        if (cnt_q == AR_M1) begin
          nxt_cnt = '0;
`ifdef PED_PHASE_EN
          if (ped_go)
            nxt_ph = PH_WALK;
          else
`endif
          if (arb_any) begin
            nxt_ph    = PH_GREEN;
            nxt_grant = arb_winner;
          end else begin
            nxt_ph = PH_IDLE;
          end
        end else begin
          nxt_cnt = cnt_q + 1'b1;
        end
      end
`ifdef PED_PHASE_EN
      PH_WALK: begin
        if (cnt_q == PED_M1) begin
          nxt_ph  = PH_ALLRED;
          nxt_cnt = '0;
        end else begin
          nxt_cnt = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        nxt_ph  = PH_IDLE;
        nxt_cnt = '0;
      end
    endcase
  end

  // phase_done is raised on entry to the final all-red cycle so it is high during that cycle.
  always_comb begin
    nxt_light = light_word(nxt_ph, nxt_grant);
    nxt_done  = (nxt_ph == PH_ALLRED) && (nxt_cnt == AR_M1);
  end

endmodule

// File: tb/tb_four_way_phase_scheduler.sv
// Self-checking bench for four_way_phase_scheduler: vector table, corner sequences, randomized model comparison.
module tb_four_way_phase_scheduler;
  import four_way_phase_scheduler_pkg::*;

  localparam int MIN_G = 10;
  localparam int MAX_G = 25;
  localparam int YEL   = 5;
  localparam int AR    = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      car_req = 4'b0000;
  logic [11:0]     light;
  logic [1:0]      grant;
  logic [PH_W-1:0] phase;
  logic            phase_done;
`ifdef PED_PHASE_EN
  logic            ped_req = 1'b0;
  logic            walk;
`endif

  always #5 clk = ~clk;

  four_way_phase_scheduler #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_T(YEL), .ALLRED_T(AR), .CNT_W(5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .car_req    (car_req),
`ifdef PED_PHASE_EN
    .ped_req    (ped_req),
    .walk       (walk),
`endif
    .light      (light),
    .grant      (grant),
    .phase      (phase),
    .phase_done (phase_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nonred(input logic [11:0] l);
    int n = 0;
    for (int i = 0; i < 4; i++)
      if (l[3*i +: 3] != 3'b100) n++;
    return n;
  endfunction

  // Reference model: phase name, unsaturated elapsed time in phase, grant.
  int m_ph, m_t, m_g;

  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++)
      if (req[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  function automatic logic [11:0] model_light(input int ph, input int g);
    logic [11:0] w = 12'h924;
    if (ph == 1) w[3*g +: 3] = 3'b001;
    if (ph == 2) w[3*g +: 3] = 3'b010;
    return w;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] req);
    logic [3:0] oth;
    if (!r) begin
      m_ph = 0; m_t = 0; m_g = 3;
    end else begin
      case (m_ph)
        0: if (req != 0) begin m_ph = 1; m_t = 0; m_g = rr_pick(req, m_g); end
        1: begin
          oth = req;
          oth[m_g] = 1'b0;
          if (m_t >= MIN_G - 1 && oth != 0 && (!req[m_g] || m_t >= MAX_G - 1)) begin
            m_ph = 2; m_t = 0;
          end else m_t++;
        end
        2: if (m_t + 1 == YEL) begin m_ph = 3; m_t = 0; end else m_t++;
        default: if (m_t + 1 == AR) begin
          m_t = 0;
          if (req != 0) begin m_ph = 1; m_g = rr_pick(req, m_g); end
          else m_ph = 0;
        end else m_t++;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] req);
    rst_n   = r;
    car_req = req;
    model_step(r, req);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    int          ph;
    int          g;
    logic [11:0] lt;
  } vec_t;

  vec_t tbl[11];
  int n, dones, idx, prev_ph;
  int gseq[5];
  int exp_seq[5] = '{0, 1, 2, 3, 0};
  logic [3:0] rq;
  logic rr;

  initial begin
    tbl[0]  = '{1'b0, 4'b0000, 0, 3, 12'h924};
    tbl[1]  = '{1'b1, 4'b0000, 0, 3, 12'h924};
    tbl[2]  = '{1'b1, 4'b0001, 1, 0, 12'h921};
    tbl[3]  = '{1'b1, 4'b0000, 1, 0, 12'h921};
    tbl[4]  = '{1'b1, 4'b0000, 1, 0, 12'h921};
    tbl[5]  = '{1'b0, 4'b1111, 0, 3, 12'h924};
    tbl[6]  = '{1'b1, 4'b1010, 1, 1, 12'h90C};
    tbl[7]  = '{1'b1, 4'b0000, 1, 1, 12'h90C};
    tbl[8]  = '{1'b0, 4'b0000, 0, 3, 12'h924};
    tbl[9]  = '{1'b1, 4'b1000, 1, 3, 12'h324};
    tbl[10] = '{1'b0, 4'b0000, 0, 3, 12'h924};

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].rst, tbl[i].req);
      check($sformatf("vec%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      check($sformatf("vec%0d_light", i), 32'(light), 32'(tbl[i].lt));
      check($sformatf("vec%0d_done", i), 32'(phase_done), 32'd0);
    end

    // Max-out: approach 0 green with 0 and 2 held.
    cycle(1'b0, 4'b0000);
    cycle(1'b1, 4'b0001);
    check("maxout_start", 32'(phase), 32'd1);
    n = 0;
    while (phase == 1 && n < 200) begin n++; cycle(1'b1, 4'b0101); end
    check("maxout_green_len", n, MAX_G);
    n = 0;
    while (phase == 2 && n < 200) begin n++; cycle(1'b1, 4'b0101); end
    check("maxout_yellow_len", n, YEL);
    n = 0; dones = 0;
    while (phase == 3 && n < 200) begin
      n++;
      if (phase_done) dones++;
      if (n == AR) check("maxout_done_last_allred", 32'(phase_done), 32'd1);
      cycle(1'b1, 4'b0101);
    end
    check("maxout_allred_len", n, AR);
    check("maxout_done_pulses", dones, 1);
    check("maxout_next_phase", 32'(phase), 32'd1);
    check("maxout_next_grant", 32'(grant), 32'd2);
    check("maxout_done_cleared", 32'(phase_done), 32'd0);

    // Gap-out before minimum green is honoured only after MIN_GREEN cycles.
    cycle(1'b0, 4'b0000);
    cycle(1'b1, 4'b0011);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0011);
    n = 4;
    while (phase == 1 && n < 200) begin n++; cycle(1'b1, 4'b0010); end
    check("gapout_green_len", n, MIN_G);
    check("gapout_yellow", 32'(phase), 32'd2);
    check("gapout_yellow_light", 32'(light), 32'h924 ^ 32'h6);

    // All four requesting: grants rotate 0,1,2,3,0.
    cycle(1'b0, 4'b0000);
    idx = 0; prev_ph = 0; n = 0;
    while (idx < 5 && n < 1000) begin
      n++;
      cycle(1'b1, 4'b1111);
      check("rr_one_nonred", nonred(light) <= 1, 1);
      if (phase == 1 && prev_ph != 1) begin gseq[idx] = grant; idx++; end
      prev_ph = phase;
    end
    check("rr_entries", idx, 5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), gseq[i], exp_seq[i]);

    // Reset mid-yellow.
    n = 0;
    while (phase != 2 && n < 200) begin n++; cycle(1'b1, 4'b1111); end
    cycle(1'b1, 4'b1111);
    check("rst_yel_was_yellow", 32'(phase), 32'd2);
    cycle(1'b0, 4'b1111);
    check("rst_yel_light", 32'(light), 32'h924);
    check("rst_yel_phase", 32'(phase), 32'd0);
    check("rst_yel_grant", 32'(grant), 32'd3);
    check("rst_yel_done", 32'(phase_done), 32'd0);

`ifdef PED_PHASE_EN
    cycle(1'b0, 4'b0000);
    cycle(1'b1, 4'b0011);
    ped_req = 1'b1;
    cycle(1'b1, 4'b0011);
    ped_req = 1'b0;
    n = 0;
    while (phase != 4 && n < 200) begin n++; cycle(1'b1, 4'b0011); end
    n = 0;
    while (phase == 4 && n < 200) begin
      n++;
      check("ped_walk", 32'(walk), 32'd1);
      check("ped_light", 32'(light), 32'h924);
      cycle(1'b1, 4'b0011);
    end
    check("ped_walk_len", n, 8);
    check("ped_then_allred", 32'(phase), 32'd3);
    n = 0;
    while (phase != 1 && n < 50) begin n++; cycle(1'b1, 4'b0011); end
    check("ped_resume_grant", 32'(grant), 32'd1);
`endif

    // Randomized run against the reference model.
    cycle(1'b0, 4'b0000);
    rq = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) rq = 4'($urandom);
      rr = ($urandom_range(399) != 0);
      cycle(rr, rq);
      check("rand_phase", 32'(phase), m_ph);
      check("rand_grant", 32'(grant), m_g);
      check("rand_light", 32'(light), 32'(model_light(m_ph, m_g)));
      check("rand_done", 32'(phase_done), 32'(m_ph == 3 && m_t == AR - 1));
      check("rand_one_nonred", nonred(light) <= 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
